// File: rtl/noc_trace_capture.sv
// Passive val/rdy link monitor. It parses header/payload framing, filters by message type,
// and captures timestamped records into a trace FIFO that a debug agent drains.
module noc_trace_capture #(
    parameter int FLIT_W = 64,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FLIT_W-1:0]        din_msg,
    input  logic                     din_val,
    output logic                     din_rdy,
    output logic [FLIT_W-1:0]        dout_msg,
    output logic                     dout_val,
    input  logic                     dout_rdy,
    input  logic                     cfg_filt_en,
    input  logic [7:0]               cfg_filt_type,
    input  logic                     cfg_cap_pay,
    input  logic                     cfg_clr,
    output logic [FLIT_W+TS_W+1:0]   trace_msg,
    output logic                     trace_val,
    input  logic                     trace_rdy,
    output logic [CNT_W-1:0]         stat_pkts,
    output logic [CNT_W-1:0]         stat_drops
);
    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = FLIT_W + TS_W + 2;
    localparam logic [AW-1:0]    PTR_ONE = AW'(1'b1);
    localparam logic [AW:0]      OCC_ONE = (AW + 1)'(1'b1);
    localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {ST_HDR = 1'b0, ST_PAY = 1'b1} state_t;

    state_t            r_state;
    logic [7:0]        r_rem;
    logic              r_sel;
    logic [TS_W-1:0]   r_ts;
    logic [REC_W-1:0]  r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_trace_val;
    logic              r_lost_pend;
    logic [CNT_W-1:0]  r_stat_pkts;
    logic [CNT_W-1:0]  r_stat_drops;

    logic              w_xfer;
    logic              w_hdr_sel;
    logic              w_push;
    logic              w_kind;
    logic              w_pop;
    logic              w_full;
    logic              w_accept;
    logic              w_drop;
    logic [AW:0]       w_count_nxt;

    assign din_rdy   = dout_rdy;
    assign dout_msg  = din_msg;
    assign dout_val  = din_val;

    assign w_xfer    = din_val & dout_rdy;
    assign w_hdr_sel = ~cfg_filt_en | (din_msg[21:14] == cfg_filt_type);
    assign w_pop     = r_trace_val & trace_rdy;
    // Occupancy reaches DEPTH only when its top bit is set, DEPTH being a power of two.
    assign w_full    = r_count[AW];
    assign w_accept  = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;

    assign trace_msg  = r_mem[r_rd_ptr];
    assign trace_val  = r_trace_val;
    assign stat_pkts  = r_stat_pkts;
    assign stat_drops = r_stat_drops;

    // Push request and record kind for the flit on the link this cycle.
    always_comb begin
        w_push = 1'b0;
        w_kind = 1'b0;
        case (r_state)
            ST_HDR: begin
                w_push = w_xfer & w_hdr_sel;
                w_kind = 1'b0;
            end
            ST_PAY: begin
                w_push = w_xfer & r_sel & cfg_cap_pay;
                w_kind = 1'b1;
            end
            default: begin
                w_push = 1'b0;
                w_kind = 1'b0;
            end
        endcase
    end

    // Next FIFO occupancy; a clear wins over any push or pop.
    always_comb begin
        w_count_nxt = r_count;
        if (cfg_clr) begin
            w_count_nxt = {(AW + 1){1'b0}};
        end else begin
            case ({w_accept, w_pop})
                2'b10:   w_count_nxt = r_count + OCC_ONE;
                2'b01:   w_count_nxt = r_count - OCC_ONE;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Packet framing FSM: header latches the filter decision and payload length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HDR;
            r_rem   <= 8'd0;
            r_sel   <= 1'b0;
        end else if (w_xfer) begin
            case (r_state)
                ST_HDR: begin
                    r_sel <= w_hdr_sel;
                    r_rem <= din_msg[29:22];
                    if (din_msg[29:22] != 8'd0) begin
                        r_state <= ST_PAY;
                    end else begin
                        r_state <= ST_HDR;
                    end
                end
                ST_PAY: begin
                    r_rem <= r_rem - 8'd1;
                    if (r_rem == 8'd1) begin
                        r_state <= ST_HDR;
                    end else begin
                        r_state <= ST_PAY;
                    end
                end
                default: r_state <= ST_HDR;
            endcase
        end
    end

    // Free-running timestamp, untouched by the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts <= {TS_W{1'b0}};
        end else begin
            r_ts <= r_ts + TS_ONE;
        end
    end

    // Trace FIFO storage, pointers and the sticky loss marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {REC_W{1'b0}};
            end
            r_wr_ptr    <= {AW{1'b0}};
            r_rd_ptr    <= {AW{1'b0}};
            r_count     <= {(AW + 1){1'b0}};
            r_trace_val <= 1'b0;
            r_lost_pend <= 1'b0;
        end else if (cfg_clr) begin
            r_wr_ptr    <= {AW{1'b0}};
            r_rd_ptr    <= {AW{1'b0}};
            r_count     <= {(AW + 1){1'b0}};
            r_trace_val <= 1'b0;
            r_lost_pend <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= {r_lost_pend, w_kind, r_ts, din_msg};
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count     <= w_count_nxt;
            r_trace_val <= (w_count_nxt != {(AW + 1){1'b0}});
            if (w_accept) begin
                r_lost_pend <= 1'b0;
            end else if (w_drop) begin
                r_lost_pend <= 1'b1;
            end else begin
                r_lost_pend <= r_lost_pend;
            end
        end
    end

    // Statistics: header count wraps, drop count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_pkts  <= {CNT_W{1'b0}};
            r_stat_drops <= {CNT_W{1'b0}};
        end else if (cfg_clr) begin
            r_stat_pkts  <= {CNT_W{1'b0}};
            r_stat_drops <= {CNT_W{1'b0}};
        end else begin
            if (w_xfer && r_state == ST_HDR) begin
                r_stat_pkts <= r_stat_pkts + CNT_ONE;
            end
            if (w_drop && r_stat_drops != CNT_MAX) begin
                r_stat_drops <= r_stat_drops + CNT_ONE;
            end
        end
    end
endmodule

// File: doc/noc_trace_capture.md
# noc_trace_capture

Parametrised, non-intrusive NoC link monitor that sits on a single val/rdy link between two routers or between a tile and the chip bridge. Flits pass through combinationally and unchanged. The block parses packet framing (header plus payload-length flits), filters packets by message type, and timestamps selected headers, and optionally their payload flits. Selected flits are written into an on-block trace FIFO that a debug agent drains over its own val/rdy port, with loss and statistics counters for post-mortem analysis.

## Interface

**Parameters**
- `FLIT_W`, default 64: flit width; header fields sit at fixed bit positions, so `FLIT_W` ≥ 64.
- `DEPTH`, default 16: trace FIFO entries; power of two, ≥ 2.
- `TS_W`, default 32: timestamp width.
- `CNT_W`, default 16: statistics counter width.

**Ports** (name, direction, width, meaning)
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `din_msg` in FLIT_W: upstream flit.
- `din_val` in 1: upstream valid.
- `din_rdy` out 1: upstream ready, equal to `dout_rdy`.
- `dout_msg` out FLIT_W: equal to `din_msg`.
- `dout_val` out 1: equal to `din_val`.
- `dout_rdy` in 1: downstream ready.
- `cfg_filt_en` in 1: 1 = capture only packets whose msg_type equals `cfg_filt_type`.
- `cfg_filt_type` in 8: message type to match.
- `cfg_cap_pay` in 1: 1 = also capture the payload flits of selected packets.
- `cfg_clr` in 1: synchronous clear of the FIFO and all counters.
- `trace_msg` out FLIT_W+TS_W+2: trace record {lost, kind, ts, flit}. `kind` is 0 for a header, 1 for a payload flit.
- `trace_val` out 1: a trace record is available.
- `trace_rdy` in 1: the debug agent accepts the record.
- `stat_pkts` out CNT_W: count of header flits seen, regardless of filter.
- `stat_drops` out CNT_W: count of records lost because the FIFO was full; saturates.

## Operation

- **Handshake.** A flit is transferred ("xfer") when `din_val & dout_rdy`. The monitor never alters or stalls the link.
- **Header fields.**
  - plen = `din_msg[29:22]`
  - msg_type = `din_msg[21:14]`
  - chip/x/y: `[63:50]`, `[49:42]`, `[41:34]` (carried in the record, not decoded)
- **FSM.** Two states, HDR and PAY.
  - HDR, on xfer:
    - Latch `sel = !cfg_filt_en | (msg_type == cfg_filt_type)`.
    - Increment `stat_pkts`, wrapping.
    - Set rem = plen.
    - Go to PAY if plen ≠ 0; otherwise stay in HDR.
  - PAY, on xfer:
    - rem ← rem − 1.
    - Return to HDR when rem == 1 (last payload flit).
  - No xfer: hold state and rem.
- **Timestamp.** A free-running TS_W counter, 0 after reset, incrementing every cycle and wrapping. A record's ts is the counter value in the xfer cycle.
- **Push.** A record is pushed when either:
  - HDR xfer with sel true (using the combinationally computed sel for that header), or
  - PAY xfer with latched sel = 1 and `cfg_cap_pay` = 1.
- **Full FIFO.**
  - A push into a full FIFO without a pop in the same cycle is dropped; `stat_drops` increments, saturating at all-ones.
  - The drop sets a sticky `lost_pend` flag.
  - The next accepted record carries lost = 1, and `lost_pend` clears in that cycle.
- **Push and pop together.** When the FIFO is full and a pop (`trace_val & trace_rdy`) happens in the same cycle as a push, the push is accepted and occupancy is unchanged. When the FIFO is empty, the pushed record is not visible until the next cycle; there is no bypass.
- **`cfg_clr`** (synchronous, highest priority):
  - FIFO emptied; `stat_pkts`, `stat_drops` and `lost_pend` zeroed.
  - Any push in that cycle is discarded and not counted.
  - FSM and timestamp are not affected.
- **Config changes.** `cfg_*` may change at any time. The filter decision is taken per packet at the header, so a mid-packet change of the filter does not affect that packet's payload. A `cfg_cap_pay` change takes effect on the next flit.
- **Reset.** Asserting `rst_n` mid-packet returns the FSM to HDR. The first flit after reset is treated as a header.

## Timing

- **Reset values:**
  - `trace_val` = 0, `stat_pkts` = 0, `stat_drops` = 0, `trace_msg` = 0
  - FSM = HDR, rem = 0, ts = 0, `lost_pend` = 0
  - `din_rdy`, `dout_msg` and `dout_val` are combinational from their inputs.
- **Passthrough** latency is 0 cycles.
- **Capture latency** is 1 cycle: a record pushed at edge N is presented on `trace_val`/`trace_msg` after edge N and is stable until popped.
- **Counters** update at the edge that ends the xfer cycle.
- **Throughput.** One push and one pop per cycle are sustained.

## Test plan

- **Filter off, one header.** Header with plen = 0 and msg_type = 0x0E at ts = 5 → one record {lost=0, kind=0, ts=5, flit}; `stat_pkts` = 1; FSM remains HDR.
- **Payload capture with stalls.** Packet with plen = 3, `cfg_cap_pay` = 1, and `dout_rdy` toggling every cycle → exactly 4 records (kinds 0,1,1,1), each ts equal to its xfer cycle; FSM back in HDR after the 3rd payload xfer.
- **Filter.** `cfg_filt_en` = 1, `cfg_filt_type` = 0x13; send types 0x13, 0x0E, 0x13, each with plen = 2 → 6 records, both packets of type 0x13 only; `stat_pkts` = 3.
- **Overflow.** `DEPTH` = 4, `trace_rdy` = 0; push 6 headers → 4 records in the FIFO, `stat_drops` = 2. Raise `trace_rdy` and send 1 more header → the 5th record read has lost = 1; later records have lost = 0.
- **Full FIFO with simultaneous push/pop.** Full FIFO, push and pop in the same cycle → push accepted, occupancy unchanged, `stat_drops` unchanged. Then pulse `cfg_clr` together with a push → FIFO empty, counters 0, nothing pushed.
- **Reset mid-packet.** Assert `rst_n` low during the payload of a plen = 5 packet → all outputs at reset values. The next flit after release is parsed as a header: `stat_pkts` = 1, and a record of kind 0 is produced.
